// File: rtl/spi_frame_tx.sv
// spi_frame_tx
//   Six-byte SPI mode-0 master transmitter. A start request (taken only while
//   idle) snapshots tx_byte0..tx_byte5 and sends them MSB first, tx_byte0
//   first, inside a single cs_n-low frame.
//
// Parameters
//   CLK_DIV   SCLK half-period in clk cycles (1..255)
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   start     frame request, sampled only while idle
//   tx_byte*  payload bytes, captured when start is accepted
//   busy      high while a frame is in progress
//   done      one-cycle pulse at frame end (with cs_n rising)
//   sclk      SPI clock, CPOL=0
//   mosi      serial data, CPHA=0
//   cs_n      active-low chip select
module spi_frame_tx #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte0,
  input  logic [7:0] tx_byte1,
  input  logic [7:0] tx_byte2,
  input  logic [7:0] tx_byte3,
  input  logic [7:0] tx_byte4,
  input  logic [7:0] tx_byte5,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] BIT_LAST = 6'd47;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  div_q,   div_d;
  logic [5:0]  bit_q,   bit_d;
  logic        half_q,  half_d;   // 0: low half of bit period, 1: high half
  logic [47:0] sr_q,    sr_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;
  logic        sclk_q,  sclk_d;
  logic        mosi_q,  mosi_d;
  logic        cs_n_q,  cs_n_d;

  // Every output is computed one cycle ahead and registered, so each output
  // value changes on the same edge as the state transition that causes it.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    half_d  = half_q;
    sr_d    = sr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        if (start) begin
          sr_d    = {tx_byte0, tx_byte1, tx_byte2, tx_byte3, tx_byte4, tx_byte5};
          mosi_d  = tx_byte0[7];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          half_d  = 1'b0;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = S_SHIFT;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
            sclk_d = 1'b1;
          end else begin
            // End of a bit period: sclk falls and the next bit is presented
            // in the same cycle.
            half_d = 1'b0;
            sclk_d = 1'b0;
            sr_d   = sr_q << 1;
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              mosi_d  = 1'b0;
              state_d = S_HOLD;
            end else begin
              bit_d  = bit_q + 6'd1;
              mosi_d = sr_q[46];
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      S_HOLD: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      half_q  <= 1'b0;
      sr_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      half_q  <= half_d;
      sr_q    <= sr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_frame_tx.sv
// Bench for spi_frame_tx: two instances (CLK_DIV=4 and CLK_DIV=1) checked
// every cycle against a timing model that derives outputs from the cycle
// offset since start was accepted, plus a mode-0 slave and directed checks.
module tb_spi_frame_tx;

  logic       clk;
  logic       rst_n [2];
  logic       start [2];
  logic [7:0] txb   [2][6];
  logic [4:0] outv  [2];   // {busy, done, sclk, mosi, cs_n}

  logic busy4, done4, sclk4, mosi4, cs4;
  logic busy1, done1, sclk1, mosi1, cs1;

  spi_frame_tx #(.CLK_DIV(4)) u_div4 (
    .clk(clk), .reset(rst_n[0]), .start(start[0]),
    .tx_byte0(txb[0][0]), .tx_byte1(txb[0][1]), .tx_byte2(txb[0][2]),
    .tx_byte3(txb[0][3]), .tx_byte4(txb[0][4]), .tx_byte5(txb[0][5]),
    .busy(busy4), .done(done4), .sclk(sclk4), .mosi(mosi4), .cs_n(cs4)
  );

  spi_frame_tx #(.CLK_DIV(1)) u_div1 (
    .clk(clk), .reset(rst_n[1]), .start(start[1]),
    .tx_byte0(txb[1][0]), .tx_byte1(txb[1][1]), .tx_byte2(txb[1][2]),
    .tx_byte3(txb[1][3]), .tx_byte4(txb[1][4]), .tx_byte5(txb[1][5]),
    .busy(busy1), .done(done1), .sclk(sclk1), .mosi(mosi1), .cs_n(cs1)
  );

  assign outv[0] = {busy4, done4, sclk4, mosi4, cs4};
  assign outv[1] = {busy1, done1, sclk1, mosi1, cs1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int dv [2] = '{4, 1};

  // ---------------- model state (updated on clk rise) ----------------
  int          mk  [2] = '{0, 0};   // cycles since accept, 0 = idle
  logic [47:0] mfr [2] = '{48'h0, 48'h0};
  int          t0  [2] = '{0, 0};
  int          cyc = 0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) mk[i] <= 0;
      else if (mk[i] == 0) begin
        if (start[i]) begin
          mk[i]  <= 1;
          mfr[i] <= {txb[i][0], txb[i][1], txb[i][2], txb[i][3], txb[i][4], txb[i][5]};
          t0[i]  <= cyc;
        end
      end else if (mk[i] == 98 * dv[i] + 1) mk[i] <= 0;
      else mk[i] <= mk[i] + 1;
    end
    cyc <= cyc + 1;
  end

  // Expected {busy,done,sclk,mosi,cs_n} k cycles after the accept cycle.
  function automatic logic [4:0] model_out(input int k, input int d, input logic [47:0] fr);
    int off, s, b;
    if (k == 0) return 5'b00001;
    if (k == 98 * d + 1) return 5'b11001;
    off = k - 1;
    if (off < d) return {1'b1, 1'b0, 1'b0, fr[47], 1'b0};
    if (off < 97 * d) begin
      s = off - d;
      b = s / (2 * d);
      return {1'b1, 1'b0, ((s % (2 * d)) >= d), fr[47 - b], 1'b0};
    end
    return 5'b10000;
  endfunction

  // ---------------- checking / slave state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [47:0] rx [2];
  logic [47:0] want [2];
  int          rises [2], lowcnt [2], gap [2], frames_done [2], done_cnt [2], done_cyc [2];
  int          last_rises [2], last_low [2];
  logic [47:0] last_frame [2];
  logic        psclk [2], pcs [2], chk_gap [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample at the falling edge, compare, run the slave, then
  // leave the caller 1 time unit after the falling edge to drive inputs.
  task automatic tick();
    logic [4:0] e;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      e = rst_n[i] ? model_out(mk[i], dv[i], mfr[i]) : 5'b00001;
      checks++;
      if (outv[i] !== e) begin
        errors++;
        $display("FAIL outputs D=%0d t=%0t k=%0d: got %b expected %b (busy,done,sclk,mosi,cs_n)",
                 dv[i], $time, mk[i], outv[i], e);
      end
      if (rst_n[i]) begin
        if (!outv[i][0]) begin
          if (pcs[i] && chk_gap[i] && frames_done[i] > 0) chk("cs_n high gap", 64'(gap[i]), 64'd2);
          lowcnt[i]++;
          if (outv[i][2] && !psclk[i]) begin
            rx[i] = {rx[i][46:0], outv[i][1]};
            rises[i]++;
          end
        end else begin
          if (!pcs[i]) begin
            frames_done[i]++;
            last_frame[i] = rx[i];
            last_rises[i] = rises[i];
            last_low[i]   = lowcnt[i];
            chk("slave frame", rx[i], want[i]);
            chk("sclk rises", 64'(rises[i]), 64'd48);
            chk("cs_n low cycles", 64'(lowcnt[i]), 64'(98 * dv[i]));
            rx[i] = '0; rises[i] = 0; lowcnt[i] = 0; gap[i] = 0;
          end
          gap[i]++;
        end
        if (outv[i][3]) begin
          done_cnt[i]++;
          done_cyc[i] = cyc;
        end
      end else begin
        rx[i] = '0; rises[i] = 0; lowcnt[i] = 0; gap[i] = 0;
      end
      psclk[i] = outv[i][2];
      pcs[i]   = outv[i][0];
    end
    #1;
  endtask

  task automatic wait_frames(input int i, input int n, input int maxc, input string name);
    int c = 0;
    while (frames_done[i] < n && c < maxc) begin tick(); c++; end
    checks++;
    if (frames_done[i] < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d frames expected %0d", name, frames_done[i], n);
    end
  endtask

  task automatic wait_rises(input int i, input int n, input int maxc);
    int c = 0;
    while (rises[i] < n && c < maxc) begin tick(); c++; end
    checks++;
    if (rises[i] < n) begin
      errors++;
      $display("FAIL rise wait timeout: got %0d rises expected %0d", rises[i], n);
    end
  endtask

  task automatic set_bytes(input int i, input logic [47:0] v);
    for (int b = 0; b < 6; b++) txb[i][b] = v[47 - 8*b -: 8];
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; start[i] = 1'b0;
      for (int b = 0; b < 6; b++) txb[i][b] = 8'h00;
      rx[i] = '0; want[i] = '0; last_frame[i] = '0;
      rises[i] = 0; lowcnt[i] = 0; gap[i] = 0; frames_done[i] = 0;
      done_cnt[i] = 0; done_cyc[i] = 0; last_rises[i] = 0; last_low[i] = 0;
      psclk[i] = 1'b0; pcs[i] = 1'b1;
    end
    chk_gap[0] = 1'b0;
    chk_gap[1] = 1'b1;

    // Reset held with start toggling.
    set_bytes(0, 48'hFFFF_FFFF_FFFF);
    set_bytes(1, 48'hFFFF_FFFF_FFFF);
    for (int n = 0; n < 8; n++) begin
      tick();
      start[0] = ~start[0];
      start[1] = ~start[1];
    end
    chk("reset outputs D4", 64'(outv[0]), 64'b00001);
    chk("reset outputs D1", 64'(outv[1]), 64'b00001);
    start[0] = 1'b0; start[1] = 1'b0;
    tick();
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    tick(); tick();

    // Single frame at CLK_DIV=4, with snapshot/ignore disturbance at T0+50.
    want[0] = 48'hA53C_FF00_817E;
    set_bytes(0, 48'hA53C_FF00_817E);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (48) tick();
    set_bytes(0, 48'h0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_frames(0, 1, 600, "single frame");
    repeat (10) tick();
    chk("D4 frame", last_frame[0], 48'hA53C_FF00_817E);
    chk("D4 rises", 64'(last_rises[0]), 64'd48);
    chk("D4 cs_n low", 64'(last_low[0]), 64'd392);
    chk("D4 done latency", 64'(done_cyc[0] - t0[0]), 64'd393);
    chk("D4 done count", 64'(done_cnt[0]), 64'd1);
    chk("D4 frame count", 64'(frames_done[0]), 64'd1);

    // Reset in the middle of a frame.
    want[0] = 48'h1234_5678_9ABC;
    set_bytes(0, 48'h1234_5678_9ABC);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_rises(0, 20, 400);
    #1 rst_n[0] = 1'b0;
    #1 chk("mid-frame reset outputs", 64'(outv[0]), 64'b00001);
    repeat (3) tick();
    rst_n[0] = 1'b1;
    tick(); tick();
    chk("no done after reset", 64'(done_cnt[0]), 64'd1);
    chk("no frame after reset", 64'(frames_done[0]), 64'd1);
    want[0] = 48'hC35A_0FF0_11EE;
    set_bytes(0, 48'hC35A_0FF0_11EE);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_frames(0, 2, 600, "frame after reset");
    repeat (5) tick();
    chk("post-reset frame", last_frame[0], 48'hC35A_0FF0_11EE);
    chk("post-reset done count", 64'(done_cnt[0]), 64'd2);

    // Back-to-back frames at CLK_DIV=1 with start held high.
    want[1] = 48'h0102_0304_0506;
    set_bytes(1, 48'h0102_0304_0506);
    start[1] = 1'b1;
    wait_frames(1, 3, 500, "back-to-back");
    start[1] = 1'b0;
    repeat (10) tick();
    chk("D1 frame count", 64'(frames_done[1]), 64'd3);
    chk("D1 done count", 64'(done_cnt[1]), 64'd3);
    chk("D1 frame", last_frame[1], 48'h0102_0304_0506);
    chk("D1 cs_n low", 64'(last_low[1]), 64'd98);
    chk("D1 idle after stop", 64'(outv[1]), 64'b00001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
